mux_nto1_rr: RTL
================

// Module: mux_nto1_rr
// PURPOSE
//   Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshake and
//   one registered output stage. Channel choice is either an explicit select (SEL mode) or
//   fair round-robin over requesting channels (RR mode), switchable at run time.
//   Successor to the combinational 2:1/4:1 muxes; sits between multiple producers and one consumer.
// PARAMETERS
//   WIDTH   8   data bits per channel
//   NUM_CH  4   number of input channels (>=2)
//   SEL_W   $clog2(NUM_CH)   localparam, width of select/channel index
// PORTS
//   clk        in   1             clock, all state on rising edge
//   rst_n      in   1             synchronous reset, active low
//   mode       in   1             0 = SEL mode, 1 = RR mode
//   sel        in   SEL_W         channel index used in SEL mode
//   in_data    in   NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
//   in_valid   in   NUM_CH        per-channel data valid
//   in_ready   out  NUM_CH        per-channel accept (combinational)
//   out_data   out  WIDTH         registered output data
//   out_ch     out  SEL_W         index of channel that produced out_data
//   out_valid  out  1             output register holds a word
//   out_ready  in   1             consumer accepts output
// BEHAVIOUR
//   Clock/reset: single clock clk; rst_n synchronous, active low.
//   Reset: out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1 (first RR candidate = ch0).
//   load_en = !out_valid | out_ready  (register empty or drained this cycle).
//   Grant (combinational, at most one channel g):
//     SEL mode: g = sel if sel < NUM_CH and in_valid[sel]; else no grant.
//     RR mode : first c with in_valid[c], searching (last_grant+1) mod NUM_CH upward with wrap.
//   in_ready[c] = load_en & grant_valid & (c == g); all other in_ready bits 0.
//   Transfer on in_valid[g] & in_ready[g]: next cycle out_data=in_data[g], out_ch=g,
//     out_valid=1; last_grant<=g (updated in both modes).
//   load_en with no grant: out_valid<=0, out_data/out_ch hold.
//   !load_en: output register holds; out_data/out_ch stable while out_valid & !out_ready.
//   Latency: 1 cycle input->output; full throughput (1 word/cycle) when out_ready held high.
//   Simultaneous drain + load: allowed, no bubble.
//   sel >= NUM_CH (non-power-of-2 NUM_CH): no grant, all in_ready 0.
//   mode/sel changes take effect on the next grant decision; a held output word is unaffected.
//   Reset mid-operation: held word discarded, state as after reset.
//   Implicit 2-state FSM: EMPTY (out_valid=0) / FULL (out_valid=1);
//     EMPTY->FULL on transfer; FULL->EMPTY on out_ready without transfer; FULL->FULL otherwise.
// STRUCTURE
//   mux_pkg: MODE_SEL=1'b0, MODE_RR=1'b1 constants; shared by future mux/arbiter blocks.
//   Sub-module rr_arbiter (NUM_CH, combinational): req, last_grant -> grant_valid, grant_idx.
//   Top: mode-select of grant source, in_ready decode, output register + last_grant register.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//   2 SEL mode, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> next cycle
//     out_data=8'hA5, out_ch=2, only in_ready[2] asserted.
//   3 RR mode, in_valid=4'b1111 held, out_ready=1 -> out_ch sequence 0,1,2,3,0 on
//     consecutive cycles, out_valid continuously 1.
//   4 RR mode, in_valid=4'b1010 -> out_ch alternates 1,3,1; channels 0 and 2 never granted.
//   5 Backpressure: out_ready=0 for 3 cycles after a load -> out_data/out_ch stable,
//     in_ready all 0; on out_ready=1 drain and new load occur in the same cycle.
//   6 Assert rst_n=0 while out_valid=1 -> next cycle out_valid=0; RR restarts at ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and types for the mux/arbiter family.
package mux_pkg;

    // Channel-choice mode encoding on the mode input
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Occupancy of a single-entry output register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } occ_state_e;

endpackage : mux_pkg

// File: rtl/mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, with wrap.
module rr_arbiter #(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    int unsigned cand;

    // Scan offsets 1..NUM_CH from last_grant; the first requester found wins.
    // Offset NUM_CH revisits last_grant itself, so a lone requester is always served.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            cand = (32'(last_grant) + off) % NUM_CH;
            if (!grant_valid && req[SEL_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(cand);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/mux_nto1_rr.sv
// N-channel W-bit mux with valid/ready per channel, one registered output stage,
// and run-time choice between explicit select and round-robin arbitration.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    occ_state_e       state;
    logic [SEL_W-1:0] last_grant;

    logic             load_en;
    logic             accept;
    logic             sel_hit;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;
    logic [WIDTH-1:0] ch_data [NUM_CH];

    // Round-robin candidate, always computed; used only in RR mode
    rr_arbiter #(
        .NUM_CH      (NUM_CH)
    ) u_rr_arbiter (
        .req         (in_valid),
        .last_grant  (last_grant),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // Unpack the flat input bus into per-channel words
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_data[c] = in_data[c*WIDTH +: WIDTH];
        end
    end

    // Register can take a word when empty or being drained; never while reset is held
    always_comb begin
        load_en = (state == ST_EMPTY) || out_ready;
        accept  = load_en && rst_n;
    end

    // Explicit select only grants an in-range, valid channel
    always_comb begin
        sel_hit = 1'b0;
        if (32'(sel) < NUM_CH) begin
            sel_hit = in_valid[sel];
        end
    end

    // Grant source chosen by mode
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = sel_hit;
            grant_idx   = sel;
        end
    end

    // A grant always targets a valid channel, so accept & grant is the transfer
    always_comb begin
        xfer = accept && grant_valid;
    end

    // One-hot ready toward the granted channel only
    always_comb begin
        in_ready = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            in_ready[c] = xfer && (grant_idx == SEL_W'(c));
        end
    end

    assign out_valid = (state == ST_FULL);

    // Output register, occupancy and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer) begin
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !xfer) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
            if (xfer) begin
                out_data   <= ch_data[grant_idx];
                out_ch     <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

endmodule : mux_nto1_rr
